// File: rtl/reg_alu_pkg.sv
// Shared definitions for the register-file/ALU pipeline: ALU opcode width and encoding.
package reg_alu_pkg;

   localparam int OP_W = 3;

   typedef enum logic [OP_W-1:0] {
      OP_ADD  = 3'd0,
      OP_SUB  = 3'd1,
      OP_AND  = 3'd2,
      OP_OR   = 3'd3,
      OP_XOR  = 3'd4,
      OP_SHL  = 3'd5,
      OP_SHR  = 3'd6,
      OP_PASS = 3'd7
   } alu_op_e;

endpackage

// File: rtl/alu_core.sv
// Combinational 8-operation ALU producing result, carry/borrow/shift-out and zero.
module alu_core
   import reg_alu_pkg::*;
#(
   parameter int WIDTH = 16
) (
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic [OP_W-1:0]  op,
   output logic [WIDTH-1:0] result,
   output logic             carry,
   output logic             zero
);

   logic [WIDTH:0] sum_s;
   logic [WIDTH:0] diff_s;

   // Opcode decode; the extra top bit of the subtraction is set exactly when a < b.
   always_comb begin
      sum_s  = {1'b0, a} + {1'b0, b};
      diff_s = {1'b0, a} - {1'b0, b};
      result = {WIDTH{1'b0}};
      carry  = 1'b0;
      case (op)
         OP_ADD: begin
            result = sum_s[WIDTH-1:0];
            carry  = sum_s[WIDTH];
         end
         OP_SUB: begin
            result = diff_s[WIDTH-1:0];
            carry  = diff_s[WIDTH];
         end
         OP_AND:  result = a & b;
         OP_OR:   result = a | b;
         OP_XOR:  result = a ^ b;
         OP_SHL: begin
            result = {a[WIDTH-2:0], 1'b0};
            carry  = a[WIDTH-1];
         end
         OP_SHR: begin
            result = {1'b0, a[WIDTH-1:1]};
            carry  = a[0];
         end
         OP_PASS: result = a;
         default: begin
            result = {WIDTH{1'b0}};
            carry  = 1'b0;
         end
      endcase
      zero = (result == {WIDTH{1'b0}});
   end

endmodule

// File: rtl/reg_alu_pipe.sv
// WIDTH x DEPTH register file with a one-stage pipelined ALU writeback path.
// Optional macro REG_ALU_BYPASS_EN forwards the pending writeback to both read ports.
module reg_alu_pipe
   import reg_alu_pkg::*;
#(
   parameter int WIDTH = 16,
   parameter int DEPTH = 8
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     sel,
   input  logic                     wr,
   input  logic [OP_W-1:0]          op,
   input  logic [$clog2(DEPTH)-1:0] rd_addr_a,
   input  logic [$clog2(DEPTH)-1:0] rd_addr_b,
   input  logic [$clog2(DEPTH)-1:0] wr_addr,
   input  logic [WIDTH-1:0]         d_in,
   output logic [WIDTH-1:0]         d_out_a,
   output logic [WIDTH-1:0]         d_out_b,
   output logic                     cout,
   output logic                     zero,
   output logic                     wb_valid
);

   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] rf_q [DEPTH];
   logic [WIDTH-1:0] rf_d [DEPTH];
   logic [WIDTH-1:0] wb_data_q, wb_data_d;
   logic [AW-1:0]    wb_addr_q, wb_addr_d;
   logic             wb_valid_q, wb_valid_d;
   logic             cout_q, cout_d;
   logic             zero_q, zero_d;

   logic [WIDTH-1:0] rd_a_s, rd_b_s;
   logic [WIDTH-1:0] alu_res_s;
   logic             alu_carry_s, alu_zero_s;
   logic             issue_s, direct_s;

   assign issue_s  = wr & sel;
   assign direct_s = wr & ~sel;

`ifdef REG_ALU_BYPASS_EN
   // Forward the pending writeback to any read port addressing its destination.
   always_comb begin
      if (wb_valid_q && (rd_addr_a == wb_addr_q)) rd_a_s = wb_data_q;
      else                                        rd_a_s = rf_q[rd_addr_a];
      if (wb_valid_q && (rd_addr_b == wb_addr_q)) rd_b_s = wb_data_q;
      else                                        rd_b_s = rf_q[rd_addr_b];
   end
`else
   assign rd_a_s = rf_q[rd_addr_a];
   assign rd_b_s = rf_q[rd_addr_b];
`endif

   alu_core #(
      .WIDTH (WIDTH)
   ) u_alu (
      .a      (rd_a_s),
      .b      (rd_b_s),
      .op     (op),
      .result (alu_res_s),
      .carry  (alu_carry_s),
      .zero   (alu_zero_s)
   );

   // Register file next state: a direct write is the younger instruction and wins a same-address collision.
   always_comb begin
      for (int i = 0; i < DEPTH; i++) begin
         if (direct_s && (wr_addr == AW'(i)))         rf_d[i] = d_in;
         else if (wb_valid_q && (wb_addr_q == AW'(i))) rf_d[i] = wb_data_q;
         else                                          rf_d[i] = rf_q[i];
      end
   end

   // Writeback stage and flags load on an ALU issue and otherwise hold.
   always_comb begin
      if (issue_s) begin
         wb_valid_d = 1'b1;
         wb_data_d  = alu_res_s;
         wb_addr_d  = wr_addr;
         cout_d     = alu_carry_s;
         zero_d     = alu_zero_s;
      end else begin
         wb_valid_d = 1'b0;
         wb_data_d  = wb_data_q;
         wb_addr_d  = wb_addr_q;
         cout_d     = cout_q;
         zero_d     = zero_q;
      end
   end

   // State registers; reset also drops any pending writeback.
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < DEPTH; i++) rf_q[i] <= {WIDTH{1'b0}};
         wb_data_q  <= {WIDTH{1'b0}};
         wb_addr_q  <= {AW{1'b0}};
         wb_valid_q <= 1'b0;
         cout_q     <= 1'b0;
         zero_q     <= 1'b0;
      end else begin
         for (int i = 0; i < DEPTH; i++) rf_q[i] <= rf_d[i];
         wb_data_q  <= wb_data_d;
         wb_addr_q  <= wb_addr_d;
         wb_valid_q <= wb_valid_d;
         cout_q     <= cout_d;
         zero_q     <= zero_d;
      end
   end

   assign d_out_a  = rd_a_s;
   assign d_out_b  = rd_b_s;
   assign cout     = cout_q;
   assign zero     = zero_q;
   assign wb_valid = wb_valid_q;

endmodule

// File: tb/tb_reg_alu_pipe.sv
// Self-checking bench for reg_alu_pipe: directed scenarios followed by randomized traffic
// checked against an architectural model (committed registers plus one pending writeback).
module tb_reg_alu_pipe;

   logic        clk;
   logic        reset;
   logic        sel;
   logic        wr;
   logic [2:0]  op;
   logic [2:0]  rd_addr_a;
   logic [2:0]  rd_addr_b;
   logic [2:0]  wr_addr;
   logic [15:0] d_in;
   logic [15:0] d_out_a;
   logic [15:0] d_out_b;
   logic        cout;
   logic        zero;
   logic        wb_valid;

   int n_checks = 0;
   int n_fail   = 0;

   logic [15:0] m_rf [8];
   bit          m_pv;
   logic [2:0]  m_pa;
   logic [15:0] m_pd;
   bit          m_c;
   bit          m_z;

   reg_alu_pipe #(
      .WIDTH (16),
      .DEPTH (8)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .sel       (sel),
      .wr        (wr),
      .op        (op),
      .rd_addr_a (rd_addr_a),
      .rd_addr_b (rd_addr_b),
      .wr_addr   (wr_addr),
      .d_in      (d_in),
      .d_out_a   (d_out_a),
      .d_out_b   (d_out_b),
      .cout      (cout),
      .zero      (zero),
      .wb_valid  (wb_valid)
   );

   initial clk = 1'b0;
   always #10 clk = ~clk;

   task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
      n_checks++;
      assert (got === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, got, exp);
      end
   endtask

   // What a read port should return given the committed registers and the pending result.
   function automatic logic [15:0] m_read(input logic [2:0] a);
`ifdef REG_ALU_BYPASS_EN
      if (m_pv && (a == m_pa)) return m_pd;
`endif
      return m_rf[a];
   endfunction

   function automatic void alu_ref(input logic [2:0] o, input logic [15:0] a, input logic [15:0] b,
                                   output logic [15:0] r, output logic c);
      int unsigned ua;
      int unsigned ub;
      ua = a;
      ub = b;
      c  = 1'b0;
      case (o)
         3'd0: begin r = 16'((ua + ub) % 65536); c = ((ua + ub) >= 65536); end
         3'd1: begin r = 16'((ua + 65536 - ub) % 65536); c = (ua < ub); end
         3'd2: r = a & b;
         3'd3: r = a | b;
         3'd4: r = a ^ b;
         3'd5: begin r = 16'((ua * 2) % 65536); c = (ua >= 32768); end
         3'd6: begin r = 16'(ua / 2); c = ((ua % 2) == 1); end
         default: r = a;
      endcase
   endfunction

   task automatic model_reset();
      for (int i = 0; i < 8; i++) m_rf[i] = 16'h0000;
      m_pv = 1'b0;
      m_pa = 3'd0;
      m_pd = 16'h0000;
      m_c  = 1'b0;
      m_z  = 1'b0;
   endtask

   task automatic check_flags();
      check("wb_valid", 16'(wb_valid), 16'(m_pv));
      check("cout", 16'(cout), 16'(m_c));
      check("zero", 16'(zero), 16'(m_z));
   endtask

   // One instruction: check the read ports before the edge, update the model, check flags after.
   task automatic step(input logic s, input logic w, input logic [2:0] o, input logic [2:0] a,
                       input logic [2:0] b, input logic [2:0] wa, input logic [15:0] d);
      logic [15:0] ea, eb, res;
      logic        c;
      sel = s; wr = w; op = o; rd_addr_a = a; rd_addr_b = b; wr_addr = wa; d_in = d;
      #2;
      ea = m_read(a);
      eb = m_read(b);
      check("d_out_a", d_out_a, ea);
      check("d_out_b", d_out_b, eb);
      alu_ref(o, ea, eb, res, c);
      @(posedge clk);
      #1;
      if (m_pv) m_rf[m_pa] = m_pd;
      if (w && !s) m_rf[wa] = d;
      m_pv = w && s;
      if (w && s) begin
         m_pa = wa;
         m_pd = res;
         m_c  = c;
         m_z  = (res == 16'h0000);
      end
      check_flags();
   endtask

   task automatic read_chk(input string tag, input logic [2:0] a, input logic [15:0] exp);
      wr = 1'b0;
      rd_addr_a = a;
      #1;
      check(tag, d_out_a, exp);
   endtask

   task automatic do_reset(input int n);
      reset = 1'b1;
      sel = 1'($urandom_range(0, 1)); wr = 1'b1; op = 3'($urandom_range(0, 7));
      rd_addr_a = 3'($urandom_range(0, 7)); rd_addr_b = 3'($urandom_range(0, 7));
      wr_addr = 3'($urandom_range(0, 7)); d_in = 16'($urandom);
      repeat (n) @(posedge clk);
      #1;
      reset = 1'b0;
      wr = 1'b0;
      model_reset();
      check_flags();
   endtask

   initial begin
      reset = 1'b0; sel = 1'b0; wr = 1'b0; op = 3'd0;
      rd_addr_a = 3'd0; rd_addr_b = 3'd0; wr_addr = 3'd0; d_in = 16'h0000;
      model_reset();

      // Garbage traffic before the model knows anything, then a two-edge reset.
      for (int i = 0; i < 4; i++) begin
         sel = 1'($urandom_range(0, 1)); wr = 1'b1; op = 3'($urandom_range(0, 7));
         wr_addr = 3'(i); d_in = 16'($urandom);
         @(posedge clk);
         #1;
      end
      do_reset(2);
      for (int i = 0; i < 8; i++) read_chk("reset_rf", 3'(i), 16'h0000);

      step(1'b0, 1'b1, 3'd0, 3'd0, 3'd0, 3'd3, 16'hcdef);
      step(1'b0, 1'b1, 3'd0, 3'd0, 3'd0, 3'd7, 16'h3210);
      step(1'b0, 1'b0, 3'd0, 3'd3, 3'd7, 3'd3, 16'h5555);
      check("rd_a_r3", d_out_a, 16'hcdef);
      check("rd_b_r7", d_out_b, 16'h3210);

      step(1'b1, 1'b1, 3'd0, 3'd3, 3'd7, 3'd2, 16'h0000);
      check("add_wbv", 16'(wb_valid), 16'h0001);
      check("add_cout", 16'(cout), 16'h0000);
      step(1'b0, 1'b0, 3'd0, 3'd2, 3'd2, 3'd0, 16'h0000);
      check("add_wbv_drop", 16'(wb_valid), 16'h0000);
      read_chk("add_r2", 3'd2, 16'hffff);

      step(1'b0, 1'b1, 3'd0, 3'd0, 3'd0, 3'd1, 16'hba98);
      step(1'b0, 1'b1, 3'd0, 3'd0, 3'd0, 3'd5, 16'h4568);
      step(1'b1, 1'b1, 3'd0, 3'd1, 3'd5, 3'd6, 16'h0000);
      check("wrap_cout", 16'(cout), 16'h0001);
      check("wrap_zero", 16'(zero), 16'h0001);
      step(1'b0, 1'b0, 3'd0, 3'd6, 3'd6, 3'd0, 16'h0000);
      read_chk("wrap_r6", 3'd6, 16'h0000);

      step(1'b0, 1'b1, 3'd0, 3'd0, 3'd0, 3'd1, 16'h0001);
      step(1'b0, 1'b1, 3'd0, 3'd0, 3'd0, 3'd5, 16'h0002);
      step(1'b1, 1'b1, 3'd1, 3'd1, 3'd5, 3'd4, 16'h0000);
      check("sub_cout", 16'(cout), 16'h0001);
      check("sub_zero", 16'(zero), 16'h0000);
      step(1'b0, 1'b0, 3'd0, 3'd4, 3'd4, 3'd0, 16'h0000);
      read_chk("sub_r4", 3'd4, 16'hffff);

      // Dependent read one cycle after issue: stale without forwarding, new sum with it.
      step(1'b1, 1'b1, 3'd0, 3'd1, 3'd5, 3'd4, 16'h0000);
`ifdef REG_ALU_BYPASS_EN
      read_chk("hazard_r4", 3'd4, 16'h0003);
`else
      read_chk("hazard_r4", 3'd4, 16'hffff);
`endif
      step(1'b0, 1'b0, 3'd0, 3'd4, 3'd4, 3'd0, 16'h0000);
      read_chk("hazard_r4_late", 3'd4, 16'h0003);

      step(1'b1, 1'b1, 3'd0, 3'd1, 3'd1, 3'd4, 16'h0000);
      step(1'b0, 1'b1, 3'd0, 3'd0, 3'd0, 3'd4, 16'h1234);
      step(1'b0, 1'b0, 3'd0, 3'd4, 3'd4, 3'd0, 16'h0000);
      read_chk("collision_r4", 3'd4, 16'h1234);

      step(1'b1, 1'b1, 3'd0, 3'd3, 3'd7, 3'd0, 16'h0000);
      check("midpipe_wbv", 16'(wb_valid), 16'h0001);
      do_reset(1);
      read_chk("midpipe_r0", 3'd0, 16'h0000);
      step(1'b0, 1'b0, 3'd0, 3'd0, 3'd3, 3'd0, 16'h0000);
      check("midpipe_r0_after", d_out_a, 16'h0000);

      for (int i = 0; i < 400; i++) begin
         if ($urandom_range(0, 59) == 0) begin
            do_reset(1);
         end else begin
            step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) != 0), 3'($urandom_range(0, 7)),
                 3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)),
                 ($urandom_range(0, 7) == 0) ? 16'h0000 : 16'($urandom));
         end
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
      $finish;
   end

endmodule
